// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin/event bundle: row inputs, column drive and the decoded key event.
// master is the scan controller, slave is the keypad/consumer side.
interface keypad_scan_ctrl_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       key_valid;
  logic [3:0] key_code;

  modport master (input rows, output cols, output key_valid, output key_code);
  modport slave  (output rows, input cols, input key_valid, input key_code);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner: synchronizes and debounces rows, emits one
// key_valid pulse with the hex code of each debounced press.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 4000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic                 clk,
  input  logic                 reset,
  keypad_scan_ctrl_if.master   kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CNT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t           state_r;
  logic [3:0]       sync1_r;
  logic [3:0]       rows_sync_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [DB_W-1:0]  db_cnt_r;
  logic [1:0]       col_r;
  logic [1:0]       row_l_r;
  logic [3:0]       cols_r;
  logic             key_valid_r;
  logic [3:0]       key_code_r;
  logic             row_high_s;

  // Hex legend of the keypad, row-major from the top-left key.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      4'd15:   code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] low_row(input logic [3:0] r);
    logic [1:0] idx;
    if (!r[0]) begin
      idx = 2'd0;
    end else if (!r[1]) begin
      idx = 2'd1;
    end else if (!r[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  assign row_high_s   = rows_sync_r[row_l_r];
  assign kp.cols      = cols_r;
  assign kp.key_valid = key_valid_r;
  assign kp.key_code  = key_code_r;

  // Two-flop synchronizer for the asynchronous row pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r     <= 4'b1111;
      rows_sync_r <= 4'b1111;
    end else begin
      sync1_r     <= kp.rows;
      rows_sync_r <= sync1_r;
    end
  end

  // Scan / debounce / hold / release sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_SCAN;
      div_cnt_r   <= '0;
      db_cnt_r    <= '0;
      col_r       <= 2'd0;
      row_l_r     <= 2'd0;
      cols_r      <= 4'b1110;
      key_valid_r <= 1'b0;
      key_code_r  <= 4'h0;
    end else begin
      key_valid_r <= 1'b0;
      case (state_r)
        ST_SCAN: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            if (rows_sync_r == 4'hF) begin
              col_r  <= col_r + 2'd1;
              cols_r <= {cols_r[2:0], cols_r[3]};
            end else begin
              row_l_r  <= low_row(rows_sync_r);
              db_cnt_r <= '0;
              state_r  <= ST_DEBOUNCE;
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (!row_high_s) begin
            if (db_cnt_r == DB_LAST) begin
              key_valid_r <= 1'b1;
              key_code_r  <= key_map(row_l_r, col_r);
              db_cnt_r    <= '0;
              state_r     <= ST_HELD;
            end else begin
              db_cnt_r <= db_cnt_r + DB_W'(1);
            end
          end else begin
            // Bounce: rescan the same column with a fresh dwell.
            div_cnt_r <= '0;
            state_r   <= ST_SCAN;
          end
        end
        ST_HELD: begin
          if (row_high_s) begin
            db_cnt_r <= '0;
            state_r  <= ST_RELEASE;
          end else begin
            state_r <= ST_HELD;
          end
        end
        ST_RELEASE: begin
          if (row_high_s) begin
            if (db_cnt_r == DB_LAST) begin
              col_r     <= col_r + 2'd1;
              cols_r    <= {cols_r[2:0], cols_r[3]};
              div_cnt_r <= '0;
              db_cnt_r  <= '0;
              state_r   <= ST_SCAN;
            end else begin
              db_cnt_r <= db_cnt_r + DB_W'(1);
            end
          end else begin
            db_cnt_r <= '0;
            state_r  <= ST_HELD;
          end
        end
        default: begin
          div_cnt_r <= '0;
          state_r   <= ST_SCAN;
        end
      endcase
    end
  end

endmodule
